// File: rtl/dm_bytelane.sv
// dm_bytelane: byte-lane data memory with valid/ready requests,
// post-reset clear sweep and 1/2-cycle response latency.
// Optional store trace log enabled by defining DM_TRACE_EN.
module dm_bytelane #(
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    logic [0:0]            r_state;
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic [31:0]           r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [1:0]            w_lane;
    logic                  w_acc;
    logic                  w_err;
    logic                  w_wr;
    logic [31:0]           w_old;
    logic [31:0]           w_new;
    logic [31:0]           w_ld;
    logic [31:0]           w_rdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    assign w_idx     = req_addr[DEPTH_LOG2+1:2];
    assign w_lane    = req_addr[1:0];
    assign req_ready = (r_state == S_IDLE);
    assign w_acc     = req_valid && req_ready;
    assign w_wr      = w_acc && req_we && !w_err;
    assign w_old     = r_mem[w_idx];
    assign w_byte    = w_old[{w_lane, 3'b000} +: 8];
    assign w_half    = w_old[{w_lane[1], 4'b0000} +: 16];
    assign w_rdata   = (w_err || req_we) ? 32'd0 : w_ld;

    // Fault detection: out of range, misaligned half/word, reserved size
    always_comb begin
        w_err = |req_addr[31:DEPTH_LOG2+2];
        case (req_size)
            2'd1:    if (req_addr[0]) w_err = 1'b1;
            2'd2:    if (req_addr[1:0] != 2'b00) w_err = 1'b1;
            2'd3:    w_err = 1'b1;
            default: ;
        endcase
    end

    // Merge store data into the addressed lanes of the current word
    always_comb begin
        w_new = w_old;
        case (req_size)
            2'd0:    w_new[{w_lane, 3'b000} +: 8] = req_wdata[7:0];
            2'd1:    w_new[{w_lane[1], 4'b0000} +: 16] = req_wdata[15:0];
            default: w_new = req_wdata;
        endcase
    end

    // Lane select and sign/zero extension for loads
    always_comb begin
        w_ld = w_old;
        case (req_size)
            2'd0: w_ld = req_unsigned ? {24'd0, w_byte}
                                      : {{24{w_byte[7]}}, w_byte};
            2'd1: w_ld = req_unsigned ? {16'd0, w_half}
                                      : {{16{w_half[15]}}, w_half};
            default: w_ld = w_old;
        endcase
    end

    // Clear sweep FSM: zero one word per cycle, then serve requests
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else if (r_state == S_CLEAR) begin
            r_ptr <= r_ptr + DEPTH_LOG2'(1);
            if (&r_ptr) r_state <= S_IDLE;
        end
    end

    // Memory array: sweep writes zeros, accepted stores write merged word
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) r_mem[r_ptr] <= 32'd0;
        else if (w_wr)          r_mem[w_idx] <= w_new;
    end

    logic        r_v1;
    logic [31:0] r_d1;
    logic        r_e1;

    // First response stage; data/err hold until the next accept
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_v1 <= 1'b0;
            r_d1 <= 32'd0;
            r_e1 <= 1'b0;
        end else begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_d1 <= w_rdata;
                r_e1 <= w_err;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic        r_v2;
            logic [31:0] r_d2;
            logic        r_e2;

            // Extra output register stage for two-cycle latency
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_v2 <= 1'b0;
                    r_d2 <= 32'd0;
                    r_e2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                        r_e2 <= r_e1;
                    end
                end
            end

            assign resp_valid = r_v2;
            assign resp_rdata = r_d2;
            assign resp_err   = r_e2;
        end else begin : g_lat1
            assign resp_valid = r_v1;
            assign resp_rdata = r_d1;
            assign resp_err   = r_e1;
        end
    endgenerate

`ifdef DM_TRACE_EN
    logic [31:0] r_trace_cnt;

    // Log each committed store with its merged word
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_trace_cnt <= 32'd0;
        end else if (w_wr) begin
            $display("%d@%h: *%h <= %h", r_trace_cnt, req_pc,
                     {req_addr[31:2], 2'b00}, w_new);
            r_trace_cnt <= r_trace_cnt + 32'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^req_pc;
`endif

endmodule
